// File: rtl/serializer_fifo.sv
// serializer_fifo: buffers parallel words of selectable valid length in a small
// FIFO and shifts each one out as a serial bit stream, MSB- or LSB-first per word.
// Words are emitted back to back with no idle cycle when the FIFO holds the next one.
//
// FSM states
//   state | meaning
//   IDLE  | nothing in shift; pops the head word as soon as the FIFO is non-empty
//   WORK  | shifting a word; bit advances on ser_ready_i, next word popped on last bit
module serializer_fifo #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic [DATA_BUS_WIDTH-1:0]     data_i,
    input  logic [DATA_MOD_WIDTH-1:0]     data_mod_i,
    input  logic                          msb_first_i,
    input  logic                          data_val_i,
    output logic                          data_ready_o,
    output logic                          ser_data_o,
    output logic                          ser_data_val_o,
    input  logic                          ser_ready_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_BUS_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // FIFO storage: one entry per word, payload plus its length and bit order
    logic [DATA_BUS_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [DATA_MOD_WIDTH-1:0] mem_mod  [FIFO_DEPTH];
    logic                      mem_msb  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic             ready;

    // Shift path for the word currently being serialised
    logic [DATA_BUS_WIDTH-1:0] shift;
    logic                      shift_msb;
    logic [CNT_W-1:0]          bit_cnt;
    logic [CNT_W-1:0]          load_cnt;

    logic push;
    logic pop;
    logic fifo_empty;
    logic advance;
    logic word_done;

    assign push       = data_val_i && ready;
    assign fifo_empty = (level == '0);
    assign advance    = (state == WORK) && ser_ready_i;
    assign word_done  = advance && (bit_cnt == CNT_W'(1));
    // A pop happens either to start from IDLE or to chain the next word onto the
    // last accepted bit, which is what removes the gap between words.
    assign pop        = !fifo_empty && ((state == IDLE) || word_done);

    // A length field of zero means the full bus width is valid.
    assign load_cnt = (mem_mod[rd_ptr] == '0) ? CNT_W'(DATA_BUS_WIDTH)
                                              : CNT_W'(mem_mod[rd_ptr]);

    // Next FIFO occupancy; simultaneous push and pop cancel out.
    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_next;
            ready <= (level_next < LVL_W'(FIFO_DEPTH));
        end
    end

    // FIFO payload write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr] <= data_i;
            mem_mod[wr_ptr]  <= data_mod_i;
            mem_msb[wr_ptr]  <= msb_first_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state <= IDLE;
        else           state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!fifo_empty) state_next = WORK;
            WORK: if (word_done && fifo_empty) state_next = IDLE;
            default: state_next = state_t'(1'bx);
        endcase
    end

    // Shift register: load on pop, otherwise move one bit per accepted bit.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shift     <= '0;
            shift_msb <= 1'b0;
            bit_cnt   <= '0;
        end else if (pop) begin
            shift     <= mem_data[rd_ptr];
            shift_msb <= mem_msb[rd_ptr];
            bit_cnt   <= load_cnt;
        end else if (advance) begin
            if (shift_msb) shift <= {shift[DATA_BUS_WIDTH-2:0], 1'b0};
            else           shift <= {1'b0, shift[DATA_BUS_WIDTH-1:1]};
            bit_cnt <= bit_cnt - CNT_W'(1);
        end
    end

    assign data_ready_o   = ready;
    assign ser_data_val_o = (state == WORK);
    assign ser_data_o     = (state == WORK) &&
                            (shift_msb ? shift[DATA_BUS_WIDTH-1] : shift[0]);
    assign busy_o         = (state == WORK) || !fifo_empty;
    assign fifo_level_o   = level;

endmodule

// File: tb/tb_serializer_fifo.sv
// Directed bench for serializer_fifo (W=16, depth 4).
module tb_serializer_fifo;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        msb_first_i;
    logic        data_val_i;
    logic        data_ready_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        ser_ready_i;
    logic        busy_o;
    logic [2:0]  fifo_level_o;

    serializer_fifo #(
        .DATA_BUS_WIDTH(16),
        .DATA_MOD_WIDTH(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk_i),
        .arst_n_i(arst_n_i),
        .data_i(data_i),
        .data_mod_i(data_mod_i),
        .msb_first_i(msb_first_i),
        .data_val_i(data_val_i),
        .data_ready_o(data_ready_o),
        .ser_data_o(ser_data_o),
        .ser_data_val_o(ser_data_val_o),
        .ser_ready_i(ser_ready_i),
        .busy_o(busy_o),
        .fifo_level_o(fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [63:0] got;
    int          got_len;
    int          val_cycles;
    logic        stab_en = 1'b0;
    logic        rnd_en  = 1'b0;
    logic        prev_val = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_bit = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        logic        msb;
        logic [15:0] exp_bits;
        int          exp_len;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_capture();
        got        = '0;
        got_len    = 0;
        val_cycles = 0;
    endtask

    // Outputs sampled on the falling edge; a bit counts when valid and ready coincide.
    always @(negedge clk_i) begin
        if (ser_data_val_o) val_cycles++;
        if (ser_data_val_o && ser_ready_i) begin
            got = {got[62:0], ser_data_o};
            got_len++;
        end
        if (stab_en && prev_val && !prev_rdy) begin
            chk("hold_val", 64'(ser_data_val_o), 64'd1);
            chk("hold_bit", 64'(ser_data_o), 64'(prev_bit));
        end
        prev_val = ser_data_val_o;
        prev_rdy = ser_ready_i;
        prev_bit = ser_data_o;
    end

    // Called just after a rising edge; returns just after the edge that took the word.
    task automatic push(input logic [15:0] d, input logic [3:0] m, input logic msb);
        int n = 0;
        data_i      = d;
        data_mod_i  = m;
        msb_first_i = msb;
        data_val_i  = 1'b1;
        @(negedge clk_i);
        while (!data_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("push_ready", 64'(data_ready_o), 64'd1);
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy_o && n < max_cycles) begin
            @(negedge clk_i);
            n++;
        end
        chk("idle_timeout", 64'(busy_o), 64'd0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_i);
        #1;
    endtask

    // Randomly toggles ser_ready_i while enabled.
    initial begin
        forever begin
            @(posedge clk_i);
            if (rnd_en) begin
                #1 ser_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hA5C3, 4'd0,  1'b1, 16'b1010010111000011, 16};
        vecs[1] = '{16'h00F1, 4'd3,  1'b0, 16'b100,              3};
        vecs[2] = '{16'h8000, 4'd1,  1'b1, 16'b1,                1};
        vecs[3] = '{16'h00F1, 4'd0,  1'b0, 16'h8F00,             16};
        vecs[4] = '{16'hB000, 4'd2,  1'b1, 16'b10,               2};
        vecs[5] = '{16'h000D, 4'd15, 1'b0, 16'h5800,             15};
        vecs[6] = '{16'hFFFE, 4'd15, 1'b1, 16'h7FFF,             15};

        // Reset held with a word offered: outputs all zero, nothing stored
        arst_n_i    = 1'b0;
        data_i      = 16'hFFFF;
        data_mod_i  = 4'd0;
        msb_first_i = 1'b1;
        data_val_i  = 1'b1;
        ser_ready_i = 1'b1;
        clear_capture();
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 64'(data_ready_o), 64'd0);
        chk("rst_val",   64'(ser_data_val_o), 64'd0);
        chk("rst_bit",   64'(ser_data_o), 64'd0);
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_level", 64'(fifo_level_o), 64'd0);
        arst_n_i = 1'b1;
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
        @(negedge clk_i);
        chk("rel_ready", 64'(data_ready_o), 64'd1);
        chk("rel_level", 64'(fifo_level_o), 64'd0);
        chk("rel_busy",  64'(busy_o), 64'd0);
        step(1);

        // Latency of a word pushed into an empty FIFO
        clear_capture();
        push(16'hA5C3, 4'd0, 1'b1);
        @(negedge clk_i);
        chk("lat_val0",   64'(ser_data_val_o), 64'd0);
        chk("lat_level1", 64'(fifo_level_o), 64'd1);
        chk("lat_busy",   64'(busy_o), 64'd1);
        @(negedge clk_i);
        chk("lat_val1",   64'(ser_data_val_o), 64'd1);
        chk("lat_level0", 64'(fifo_level_o), 64'd0);
        chk("lat_bit0",   64'(ser_data_o), 64'd1);
        wait_idle(100);
        chk("lat_bits",   got, 64'hA5C3);
        chk("lat_vcyc",   64'(val_cycles), 64'd16);
        step(2);

        // Table of single words
        for (int i = 0; i < 7; i++) begin
            clear_capture();
            push(vecs[i].data, vecs[i].mod, vecs[i].msb);
            wait_idle(100);
            chk($sformatf("vec%0d_bits", i), got, 64'(vecs[i].exp_bits));
            chk($sformatf("vec%0d_len", i), 64'(got_len), 64'(vecs[i].exp_len));
            chk($sformatf("vec%0d_vcyc", i), 64'(val_cycles), 64'(vecs[i].exp_len));
            step(2);
        end

        // Back-to-back words: 3-bit LSB-first then 1-bit MSB-first, no gap
        clear_capture();
        push(16'h00F1, 4'd3, 1'b0);
        push(16'h8000, 4'd1, 1'b1);
        wait_idle(100);
        chk("b2b_bits", got, 64'b1001);
        chk("b2b_len",  64'(got_len), 64'd4);
        chk("b2b_vcyc", 64'(val_cycles), 64'd4);
        step(2);

        // Back-pressure: fill shift plus FIFO, offer a sixth word that is refused
        clear_capture();
        ser_ready_i = 1'b0;
        push(16'h9000, 4'd4, 1'b1);
        push(16'hA000, 4'd4, 1'b1);
        push(16'h3000, 4'd4, 1'b1);
        push(16'h6000, 4'd4, 1'b1);
        push(16'hC000, 4'd4, 1'b1);
        @(negedge clk_i);
        chk("full_level", 64'(fifo_level_o), 64'd4);
        chk("full_ready", 64'(data_ready_o), 64'd0);
        chk("full_val",   64'(ser_data_val_o), 64'd1);
        chk("full_busy",  64'(busy_o), 64'd1);
        step(1);
        data_i      = 16'hF000;
        data_mod_i  = 4'd4;
        msb_first_i = 1'b1;
        data_val_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rej_ready", 64'(data_ready_o), 64'd0);
            chk("rej_level", 64'(fifo_level_o), 64'd4);
        end
        step(1);
        data_val_i  = 1'b0;
        ser_ready_i = 1'b1;
        step(1);
        wait_idle(200);
        chk("bp_bits", got, 64'h9A36C);
        chk("bp_len",  64'(got_len), 64'd20);
        step(2);

        // Random back-pressure: sequence identical, bit held while not ready
        clear_capture();
        stab_en = 1'b1;
        rnd_en  = 1'b1;
        push(16'hA5C3, 4'd0, 1'b1);
        push(16'h000D, 4'd15, 1'b0);
        wait_idle(600);
        rnd_en = 1'b0;
        step(2);
        stab_en     = 1'b0;
        ser_ready_i = 1'b1;
        chk("rnd_bits", got, {33'd0, 16'hA5C3, 15'h5800});
        chk("rnd_len",  64'(got_len), 64'd31);
        step(2);

        // Reset mid-word with two words queued
        ser_ready_i = 1'b0;
        push(16'h1234, 4'd0, 1'b1);
        push(16'h5678, 4'd0, 1'b1);
        push(16'h9ABC, 4'd0, 1'b1);
        @(negedge clk_i);
        chk("pre_level", 64'(fifo_level_o), 64'd2);
        step(1);
        ser_ready_i = 1'b1;
        step(3);
        #3 arst_n_i = 1'b0;
        #1;
        chk("mid_val",   64'(ser_data_val_o), 64'd0);
        chk("mid_busy",  64'(busy_o), 64'd0);
        chk("mid_level", 64'(fifo_level_o), 64'd0);
        chk("mid_ready", 64'(data_ready_o), 64'd0);
        repeat (2) @(negedge clk_i);
        arst_n_i = 1'b1;
        clear_capture();
        repeat (20) @(negedge clk_i);
        chk("post_len",   64'(got_len), 64'd0);
        chk("post_vcyc",  64'(val_cycles), 64'd0);
        chk("post_busy",  64'(busy_o), 64'd0);
        chk("post_level", 64'(fifo_level_o), 64'd0);
        chk("post_ready", 64'(data_ready_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
